vector_m2m_integration: RTL and testbench

- Top-level integration of the memory-to-memory vector processor: program counter, instruction memory, data memory, vector ALU and control FSM in one block.
- After reset release it runs the preloaded program from instruction address 0 until a HALT instruction, then raises Done.
- All operands and results live in data memory; there is no architectural register file.
- The only external interface is clock, reset and Done. Benches inspect the internal arrays imem and dmem hierarchically.

---
 rtl/vector_m2m_integration.sv | 108 ++++++++++
 tb/tb_vector_m2m_integration.sv | 136 +++++++++++++
 2 files changed

// File: rtl/vector_m2m_integration.sv
// vector_m2m_integration: memory-to-memory vector processor (pc, imem, dmem, vector ALU, control FSM)
module vector_m2m_integration #(
    parameter DATA_W    = 16,
    parameter DADDR_W   = 8,
    parameter IADDR_W   = 8,
    parameter IMEM_FILE = "imem.hex",
    parameter DMEM_FILE = "dmem.hex"
) (
    input  logic clk,
    input  logic reset,
    output logic Done
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] RDA    = 3'd2;
    localparam logic [2:0] RDB    = 3'd3;
    localparam logic [2:0] WR     = 3'd4;
    localparam logic [2:0] HALTED = 3'd5;

    // Images are placed into imem/dmem by the load flow; an identical name for both is just a shared image.
    if (IMEM_FILE == DMEM_FILE) begin : g_shared_image
    end

    logic [31:0]        imem [0:(1<<IADDR_W)-1] = '{default: '0};
    logic [DATA_W-1:0]  dmem [0:(1<<DADDR_W)-1];

    logic [2:0]         state;
    logic [IADDR_W-1:0] pc;
    logic [31:0]        ir;
    logic [DATA_W-1:0]  a_reg, b_reg, res;
    logic [3:0]         i;

    logic [3:0]         op, len;
    logic [DADDR_W-1:0] dst_addr, a_addr, b_addr;

    assign op       = ir[31:28];
    assign len      = ir[27:24];
    assign dst_addr = ir[23:16] + {4'h0, i};
    assign a_addr   = ir[15:8] + {4'h0, i};
    assign b_addr   = ir[7:0] + {4'h0, i};

    // Element result; VSET zero-extends the immediate held in the b field.
    always_comb begin
        res = {8'h00, ir[7:0]};
        res = op == 4'd1 ? a_reg + b_reg :
              op == 4'd2 ? a_reg - b_reg :
              op == 4'd3 ? a_reg & b_reg :
              op == 4'd4 ? a_reg | b_reg :
              op == 4'd5 ? a_reg ^ b_reg :
              op == 4'd6 ? a_reg : res;
    end

    // Control FSM: fetch, decode, then read-A / read-B / write per element.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            a_reg <= '0;
            b_reg <= '0;
            i     <= '0;
            Done  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= imem[pc];
                    state <= DECODE;
                end
                DECODE: begin
                    i <= '0;
                    if (op == 4'd0) begin
                        state <= HALTED;
                        Done  <= 1'b1;
                    end else if (op[3] || len == 4'd0) begin
                        pc    <= pc + 1'b1;
                        state <= FETCH;
                    end else begin
                        state <= RDA;
                    end
                end
                RDA: begin
                    a_reg <= dmem[a_addr];
                    state <= RDB;
                end
                RDB: begin
                    b_reg <= dmem[b_addr];
                    state <= WR;
                end
                WR: begin
                    i <= i + 4'd1;
                    if (i + 4'd1 == len) begin
                        pc    <= pc + 1'b1;
                        state <= FETCH;
                    end else begin
                        state <= RDA;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

    // Data memory write port; contents survive reset, and reset forces the FSM out of WR.
    always_ff @(posedge clk) begin
        if (state == WR) dmem[dst_addr] <= res;
    end
endmodule

// File: tb/tb_vector_m2m_integration.sv
// tb_vector_m2m_integration: directed programs with hand-computed memory results and cycle counts
module tb_vector_m2m_integration;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic done;
    int   n_cmp = 0;
    int   n_bad = 0;

    vector_m2m_integration dut (.clk(clk), .reset(reset), .Done(done));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] len,
                                        input logic [7:0] d, input logic [7:0] a, input logic [7:0] b);
        return {op, len, d, a, b};
    endfunction

    // Assert reset and clear the program (all-zero words are HALT).
    task automatic hold_reset();
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 256; k++) dut.imem[k] = 32'h0;
    endtask

    // Release reset and count rising edges until Done, bounded.
    task automatic go(input string tag, input int exp);
        int n;
        n = 0;
        @(negedge clk) reset = 1'b1;
        while (n < 500) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        check(tag, n, exp);
    endtask

    initial begin
        int bad;
        // HALT at address 0
        hold_reset();
        repeat (2) @(posedge clk);
        #1 check("done_in_reset", {31'b0, done}, 0);
        go("halt_cycles", 2);
        bad = 0;
        repeat (120) begin
            @(posedge clk);
            #1 if (!done) bad++;
        end
        check("done_held", bad, 0);

        // VSET then HALT
        hold_reset();
        dut.imem[0] = ins(7, 4, 8'h10, 8'h00, 8'h2A);
        dut.dmem[8'h14] = 16'h1234;
        for (int k = 0; k < 4; k++) dut.dmem[8'h10 + k] = 16'h0;
        go("vset_cycles", 16);
        check("vset_10", dut.dmem[8'h10], 16'h002A);
        check("vset_13", dut.dmem[8'h13], 16'h002A);
        check("vset_14_kept", dut.dmem[8'h14], 16'h1234);

        // VADD then VSUB
        hold_reset();
        dut.imem[0] = ins(1, 4, 8'h20, 8'h00, 8'h08);
        dut.imem[1] = ins(2, 4, 8'h30, 8'h00, 8'h08);
        dut.dmem[0] = 16'd1;  dut.dmem[1] = 16'd2;  dut.dmem[2] = 16'd3;  dut.dmem[3] = 16'hFFFF;
        dut.dmem[8] = 16'd10; dut.dmem[9] = 16'd20; dut.dmem[10] = 16'd30; dut.dmem[11] = 16'd2;
        go("addsub_cycles", 30);
        check("vadd_0", dut.dmem[8'h20], 16'd11);
        check("vadd_2", dut.dmem[8'h22], 16'd33);
        check("vadd_wrap", dut.dmem[8'h23], 16'h0001);
        check("vsub_0", dut.dmem[8'h30], 16'hFFF7);
        check("vsub_1", dut.dmem[8'h31], 16'hFFEE);
        check("vsub_3", dut.dmem[8'h33], 16'hFFFD);

        // Logic ops with source address wrap FE, FF, 00
        hold_reset();
        dut.imem[0] = ins(3, 3, 8'h60, 8'hFE, 8'h50);
        dut.imem[1] = ins(4, 3, 8'h70, 8'hFE, 8'h50);
        dut.imem[2] = ins(5, 3, 8'h80, 8'hFE, 8'h50);
        dut.dmem[8'hFE] = 16'hF0F0; dut.dmem[8'hFF] = 16'h1234; dut.dmem[8'h00] = 16'hFFFF;
        dut.dmem[8'h50] = 16'h0FF0; dut.dmem[8'h51] = 16'hFF00; dut.dmem[8'h52] = 16'h5555;
        go("logic_cycles", 35);
        check("vand_0", dut.dmem[8'h60], 16'h00F0);
        check("vand_1", dut.dmem[8'h61], 16'h1200);
        check("vand_wrap", dut.dmem[8'h62], 16'h5555);
        check("vor_0", dut.dmem[8'h70], 16'hFFF0);
        check("vor_1", dut.dmem[8'h71], 16'hFF34);
        check("vxor_1", dut.dmem[8'h81], 16'hED34);
        check("vxor_wrap", dut.dmem[8'h82], 16'hAAAA);

        // Overlapping VCOPY, NOP, zero-length VADD
        hold_reset();
        dut.imem[0] = ins(6, 3, 8'h41, 8'h40, 8'h00);
        dut.imem[1] = ins(9, 3, 8'h90, 8'h40, 8'h40);
        dut.imem[2] = ins(1, 0, 8'h91, 8'h40, 8'h40);
        dut.dmem[8'h40] = 16'd7;
        for (int k = 1; k < 4; k++) dut.dmem[8'h40 + k] = 16'h0;
        dut.dmem[8'h90] = 16'hBEEF; dut.dmem[8'h91] = 16'hBEEF;
        go("copy_nop_cycles", 17);
        check("vcopy_41", dut.dmem[8'h41], 16'd7);
        check("vcopy_42", dut.dmem[8'h42], 16'd7);
        check("vcopy_43", dut.dmem[8'h43], 16'd7);
        check("nop_nowrite", dut.dmem[8'h90], 16'hBEEF);
        check("len0_nowrite", dut.dmem[8'h91], 16'hBEEF);

        // Reset during element-2 RDB of a len=8 VSET
        hold_reset();
        dut.imem[0] = ins(7, 8, 8'hA0, 8'h00, 8'h55);
        for (int k = 0; k < 8; k++) dut.dmem[8'hA0 + k] = 16'h0;
        @(negedge clk) reset = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_e0", dut.dmem[8'hA0], 16'h0055);
        check("abort_e1", dut.dmem[8'hA1], 16'h0055);
        check("abort_e2", dut.dmem[8'hA2], 16'h0000);
        check("abort_e3", dut.dmem[8'hA3], 16'h0000);
        check("abort_done", {31'b0, done}, 0);
        go("rerun_cycles", 28);
        check("rerun_e2", dut.dmem[8'hA2], 16'h0055);
        check("rerun_e7", dut.dmem[8'hA7], 16'h0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
